// File: rtl/calc_pkg.sv
// Shared opcode and state definitions for the calculator datapath and its capture FSM.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package calc_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // One-hot sequencer states; bit positions map directly onto the Q* outputs.
    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_ADDSUB = 6'b000010,
        S_MUL    = 6'b000100,
        S_DIV    = 6'b001000,
        S_ERR    = 6'b010000,
        S_FIN    = 6'b100000
    } state_t;

endpackage

// File: rtl/calc_addsub.sv
// Single shared WIDTH-bit add/subtract unit; bit WIDTH is carry-out (add) or borrow (sub).
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: x, y - operands; sub - 1 selects x-y, 0 selects x+y; s - WIDTH+1-bit result.
module calc_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH:0]   s
);

    // Zero-extending both operands makes the top bit a borrow (x<y) on subtract.
    assign s = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});

endmodule

// File: rtl/calc_iter_sequencer.sv
// Multi-cycle ADD/SUB/MUL/DIV sequencer on one shared adder; MUL by repeated add, DIV by repeated subtract.
// Latency: Start cycle 0 -> Done cycle 2 (ADD/SUB, DIV by 0), B+2 (MUL), floor(A/B)+2 (DIV).
// Backpressure: Start is only sampled while Busy=0; requests in any other state are dropped.
//
// Ports: Clk, Reset (sync, active-high); Start/Op/A/B request; Busy, Done handshake;
//        Result, Remainder, Flag, Err registered results; QIdle..QFin one-hot state view.
module calc_iter_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Remainder,
    output logic             Flag,
    output logic             Err,
    output logic             QIdle,
    output logic             QAddSub,
    output logic             QMul,
    output logic             QDiv,
    output logic             QErr,
    output logic             QFin
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc;   // MUL accumulator / DIV running remainder
    logic [WIDTH-1:0] cnt;   // MUL remaining count / DIV quotient

    logic [WIDTH-1:0] au_x, au_y;
    logic             au_sub;
    logic [WIDTH:0]   au_s;
    logic             au_cout;

    calc_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x   (au_x),
        .y   (au_y),
        .sub (au_sub),
        .s   (au_s)
    );

    assign au_cout = au_s[WIDTH];

    // Operand steering for the shared unit.
    always_comb begin
        au_x   = a_q;
        au_y   = b_q;
        au_sub = 1'b0;
        case (state)
            S_ADDSUB: au_sub = (op_q == OP_SUB);
            S_MUL: begin
                au_x = acc;
                au_y = a_q;
            end
            S_DIV: begin
                // Borrow out of rem-B means rem<B, which ends the division.
                au_x   = acc;
                au_y   = b_q;
                au_sub = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MUL:  state_nxt = S_MUL;
                        OP_DIV:  state_nxt = (B == '0) ? S_ERR : S_DIV;
                        default: state_nxt = S_ADDSUB;
                    endcase
                end
            end
            S_ADDSUB: state_nxt = S_FIN;
            S_MUL:    if (cnt == '0) state_nxt = S_FIN;
            S_DIV:    if (au_cout) state_nxt = S_FIN;
            S_ERR:    state_nxt = S_FIN;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            Result    <= '0;
            Remainder <= '0;
            Flag      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        op_q      <= Op;
                        a_q       <= A;
                        b_q       <= B;
                        acc       <= (Op == OP_DIV) ? A : '0;
                        cnt       <= (Op == OP_MUL) ? B : '0;
                        Result    <= '0;
                        Remainder <= '0;
                        Flag      <= 1'b0;
                        Err       <= 1'b0;
                    end
                end
                S_ADDSUB: begin
                    Result <= au_s[WIDTH-1:0];
                    Flag   <= au_cout;
                end
                S_MUL: begin
                    if (cnt != '0) begin
                        acc <= au_s[WIDTH-1:0];
                        cnt <= cnt - ONE;
                        // Sticky: once the product has wrapped it stays overflowed.
                        if (au_cout) Flag <= 1'b1;
                    end else begin
                        Result <= acc;
                    end
                end
                S_DIV: begin
                    if (!au_cout) begin
                        acc <= au_s[WIDTH-1:0];
                        cnt <= cnt + ONE;
                    end else begin
                        Result    <= cnt;
                        Remainder <= acc;
                    end
                end
                S_ERR: begin
                    Err    <= 1'b1;
                    Result <= '0;
                end
                default: ;
            endcase
        end
    end

    assign Busy    = (state != S_IDLE);
    assign Done    = (state == S_FIN);
    assign QIdle   = state[0];
    assign QAddSub = state[1];
    assign QMul    = state[2];
    assign QDiv    = state[3];
    assign QErr    = state[4];
    assign QFin    = state[5];

endmodule

// File: tb/tb_calc_iter_sequencer.sv
module tb_calc_iter_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [15:0] A, B;
    logic        Busy, Done, Flag, Err;
    logic [15:0] Result, Remainder;
    logic        QIdle, QAddSub, QMul, QDiv, QErr, QFin;

    calc_iter_sequencer #(.WIDTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .Result(Result), .Remainder(Remainder),
        .Flag(Flag), .Err(Err), .QIdle(QIdle), .QAddSub(QAddSub), .QMul(QMul),
        .QDiv(QDiv), .QErr(QErr), .QFin(QFin)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] res;
        logic [15:0] rem;
        logic        flag;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [16:0] s;
        logic [31:0] p;
        e.res = '0; e.rem = '0; e.flag = 1'b0; e.err = 1'b0; e.lat = 2;
        case (op)
            2'b00: begin s = {1'b0, a} + {1'b0, b}; e.res = s[15:0]; e.flag = s[16]; end
            2'b01: begin e.res = a - b; e.flag = (a < b); end
            2'b10: begin
                p = {16'h0, a} * {16'h0, b};
                e.res = p[15:0]; e.flag = (p > 32'h0000FFFF); e.lat = int'(b) + 2;
            end
            default: begin
                if (b == 16'h0) e.err = 1'b1;
                else begin e.res = a / b; e.rem = a % b; e.lat = int'(a / b) + 2; end
            end
        endcase
        return e;
    endfunction

    // Launch one request in cycle 0, queue its expected outcome; returns at the cycle-1 sample point.
    task automatic drive_start(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        sb.push_back(model(op, a, b));
        @(negedge Clk);
        Start = 1'b0; Op = 2'($urandom); A = 16'($urandom); B = 16'($urandom);
    endtask

    // Cycle index at which Done is seen, counted from the Start cycle; -1 if the bound expires.
    task automatic wait_done(input int bound, output int cyc);
        cyc = 1;
        while (Done !== 1'b1 && cyc < bound) begin
            @(negedge Clk);
            cyc++;
        end
        if (Done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = 16'h0; B = 16'h0;
        repeat (3) @(negedge Clk);
        chk_cnt++;
        if ({QIdle, QAddSub, QMul, QDiv, QErr, QFin} !== 6'b100000)
            $display("FAIL reset_state: got %b want 100000", {QIdle, QAddSub, QMul, QDiv, QErr, QFin});
        else pass_cnt++;
        chk_cnt++;
        if ({Busy, Done, Flag, Err, Result, Remainder} !== 36'h0)
            $display("FAIL reset_outputs: got busy=%b done=%b flag=%b err=%b res=%h rem=%h want all 0",
                     Busy, Done, Flag, Err, Result, Remainder);
        else pass_cnt++;
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_addsub;
        logic [1:0]  ops[4];
        logic [15:0] as[4];
        logic [15:0] bs[4];
        exp_t e;
        int   cyc;
        ops = '{2'b00, 2'b01, 2'b01, 2'b00};
        as  = '{16'hFFFF, 16'd3, 16'd9, 16'($urandom)};
        bs  = '{16'h0002, 16'd5, 16'd4, 16'($urandom)};
        for (int i = 0; i < 4; i++) begin
            drive_start(ops[i], as[i], bs[i]);
            chk_cnt++;
            if (QAddSub !== 1'b1 || Busy !== 1'b1) $display("FAIL addsub[%0d] state1: got qaddsub=%b busy=%b want 1 1", i, QAddSub, Busy);
            else pass_cnt++;
            wait_done(e_bound(4), cyc);
            e = sb.pop_front();
            chk_cnt++;
            if (cyc !== e.lat) $display("FAIL addsub[%0d] done_cycle: got %0d want %0d", i, cyc, e.lat);
            else pass_cnt++;
            chk_cnt++;
            if (Result !== e.res || Flag !== e.flag || Err !== 1'b0 || Remainder !== 16'h0)
                $display("FAIL addsub[%0d] result: got res=%h flag=%b err=%b rem=%h want res=%h flag=%b err=0 rem=0",
                         i, Result, Flag, Err, Remainder, e.res, e.flag);
            else pass_cnt++;
            @(negedge Clk);
            chk_cnt++;
            if (QIdle !== 1'b1 || Done !== 1'b0 || Result !== e.res)
                $display("FAIL addsub[%0d] hold: got qidle=%b done=%b res=%h want 1 0 %h", i, QIdle, Done, Result, e.res);
            else pass_cnt++;
        end
    endtask

    function automatic int e_bound(input int lat);
        return lat + 20;
    endfunction

    task automatic test_mul;
        logic [15:0] as[4];
        logic [15:0] bs[4];
        exp_t e;
        int   cyc;
        as = '{16'd7, 16'h0100, 16'd5, 16'($urandom)};
        bs = '{16'd6, 16'h0100, 16'd0, 16'($urandom_range(1, 30))};
        for (int i = 0; i < 4; i++) begin
            drive_start(2'b10, as[i], bs[i]);
            chk_cnt++;
            if (QMul !== 1'b1) $display("FAIL mul[%0d] state1: got qmul=%b want 1", i, QMul);
            else pass_cnt++;
            wait_done(e_bound(int'(bs[i]) + 2), cyc);
            e = sb.pop_front();
            chk_cnt++;
            if (cyc !== e.lat) $display("FAIL mul[%0d] done_cycle: got %0d want %0d", i, cyc, e.lat);
            else pass_cnt++;
            chk_cnt++;
            if (Result !== e.res || Flag !== e.flag || Err !== 1'b0 || Remainder !== 16'h0)
                $display("FAIL mul[%0d] result: got res=%h flag=%b err=%b rem=%h want res=%h flag=%b err=0 rem=0",
                         i, Result, Flag, Err, Remainder, e.res, e.flag);
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_div;
        logic [15:0] as[4];
        logic [15:0] bs[4];
        exp_t e;
        int   cyc;
        as = '{16'd100, 16'd3, 16'd9, 16'($urandom_range(0, 400))};
        bs = '{16'd7, 16'd8, 16'd0, 16'($urandom_range(9, 40))};
        for (int i = 0; i < 4; i++) begin
            drive_start(2'b11, as[i], bs[i]);
            chk_cnt++;
            if (QDiv !== (bs[i] != 16'h0) || QErr !== (bs[i] == 16'h0))
                $display("FAIL div[%0d] state1: got qdiv=%b qerr=%b want %b %b", i, QDiv, QErr, bs[i] != 16'h0, bs[i] == 16'h0);
            else pass_cnt++;
            wait_done(e_bound(int'(as[i]) + 2), cyc);
            e = sb.pop_front();
            chk_cnt++;
            if (cyc !== e.lat) $display("FAIL div[%0d] done_cycle: got %0d want %0d", i, cyc, e.lat);
            else pass_cnt++;
            chk_cnt++;
            if (Result !== e.res || Remainder !== e.rem || Err !== e.err || Flag !== 1'b0)
                $display("FAIL div[%0d] result: got res=%h rem=%h err=%b flag=%b want res=%h rem=%h err=%b flag=0",
                         i, Result, Remainder, Err, Flag, e.res, e.rem, e.err);
            else pass_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_abort;
        exp_t e;
        int   cyc;
        bit   done_seen = 1'b0;
        @(negedge Clk);
        Start = 1'b1; Op = 2'b10; A = 16'd10; B = 16'd1000;
        for (int c = 1; c <= 21; c++) begin
            @(negedge Clk);
            if (Done === 1'b1) done_seen = 1'b1;
            if (c == 1) Start = 1'b0;
            if (c == 5) begin Start = 1'b1; Op = 2'b00; A = 16'd1; B = 16'd1; end
            if (c == 6) begin
                Start = 1'b0;
                chk_cnt++;
                if (QMul !== 1'b1 || Busy !== 1'b1) $display("FAIL abort ignore_start: got qmul=%b busy=%b want 1 1", QMul, Busy);
                else pass_cnt++;
            end
            if (c == 20) Reset = 1'b1;
        end
        chk_cnt++;
        if ({QIdle, QAddSub, QMul, QDiv, QErr, QFin} !== 6'b100000 ||
            {Busy, Done, Flag, Err, Result, Remainder} !== 36'h0)
            $display("FAIL abort reset_state: got q=%b busy=%b done=%b flag=%b err=%b res=%h rem=%h want q=100000 rest 0",
                     {QIdle, QAddSub, QMul, QDiv, QErr, QFin}, Busy, Done, Flag, Err, Result, Remainder);
        else pass_cnt++;
        chk_cnt++;
        if (done_seen !== 1'b0) $display("FAIL abort no_done: got done pulse %b want 0", done_seen);
        else pass_cnt++;
        Reset = 1'b0;
        drive_start(2'b00, 16'd1, 16'd1);
        wait_done(e_bound(2), cyc);
        e = sb.pop_front();
        chk_cnt++;
        if (cyc !== e.lat || Result !== e.res || Flag !== e.flag)
            $display("FAIL abort restart_add: got cyc=%0d res=%h flag=%b want cyc=%0d res=%h flag=%b",
                     cyc, Result, Flag, e.lat, e.res, e.flag);
        else pass_cnt++;
        @(negedge Clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] as[3];
        logic [15:0] bs[3];
        int   done_cyc[$];
        int   want_cyc[3];
        int   n = 0;
        exp_t e;
        as = '{16'd3, 16'hFFFF, 16'd100};
        bs = '{16'd4, 16'h0002, 16'd23};
        want_cyc = '{2, 5, 8};
        @(negedge Clk);
        Start = 1'b1; Op = 2'b00; A = as[0]; B = bs[0];
        sb.push_back(model(2'b00, as[0], bs[0]));
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk);
            if (c == 4 || c == 7) begin
                chk_cnt++;
                if (Result !== 16'h0 || Flag !== 1'b0)
                    $display("FAIL b2b clear_c%0d: got res=%h flag=%b want 0 0", c, Result, Flag);
                else pass_cnt++;
            end
            if (Done === 1'b1) begin
                done_cyc.push_back(c);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk_cnt++;
                    if (Result !== e.res || Flag !== e.flag)
                        $display("FAIL b2b result%0d: got res=%h flag=%b want res=%h flag=%b", n, Result, Flag, e.res, e.flag);
                    else pass_cnt++;
                end
                n++;
                if (n < 3) begin
                    A = as[n]; B = bs[n];
                    sb.push_back(model(2'b00, as[n], bs[n]));
                end else begin
                    Start = 1'b0;
                end
            end
        end
        Start = 1'b0;
        chk_cnt++;
        if (done_cyc.size() !== 3) $display("FAIL b2b done_count: got %0d want 3", done_cyc.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < done_cyc.size(); i++) begin
            chk_cnt++;
            if (done_cyc[i] !== want_cyc[i]) $display("FAIL b2b done_cycle%0d: got %0d want %0d", i, done_cyc[i], want_cyc[i]);
            else pass_cnt++;
        end
        sb.delete();
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
